// File: rtl/bit_index_emit_if.sv
// Shared feature types and the handshake bundle between a feature-word
// producer, the set-bit index emitter and its index/count consumer.

package bit_index_emit_pkg;
    typedef logic [7:0] feature_t;
    typedef logic [3:0] feature_count_t;
endpackage

interface bit_index_emit_if #(
    parameter type data_t  = bit_index_emit_pkg::feature_t,
    parameter type index_t = logic [$clog2($bits(data_t))-1:0],
    parameter type count_t = bit_index_emit_pkg::feature_count_t
);
    logic   data_vld;
    data_t  data_i;
    logic   ready;
    logic   idx_vld;
    index_t idx_o;
    logic   idx_last;
    logic   idx_rdy;
    logic   done_vld;
    count_t count_o;

    // Producer/consumer side: offers words, accepts indices.
    modport master (
        output data_vld, data_i, idx_rdy,
        input  ready, idx_vld, idx_o, idx_last, done_vld, count_o
    );

    // Emitter side.
    modport slave (
        input  data_vld, data_i, idx_rdy,
        output ready, idx_vld, idx_o, idx_last, done_vld, count_o
    );
endinterface

// File: rtl/bit_index_emit.sv
// Serial set-bit index emitter: takes one feature word, streams the index of
// every set bit lowest-first (one per handshake), then pulses the total count.

module bit_index_emit #(
    parameter type data_t  = bit_index_emit_pkg::feature_t,
    parameter type index_t = logic [$clog2($bits(data_t))-1:0],
    parameter type count_t = bit_index_emit_pkg::feature_count_t
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_index_emit_if.slave bus
);

    localparam int W = $bits(data_t);

    // The count must be able to hold W itself (all bits set).
    if ($bits(count_t) < $clog2(W + 1)) begin : g_count_width_check
        $error("bit_index_emit: count_t is too narrow to hold W");
    end

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    count_t         count_q, count_d;

    logic [W-1:0]   lowest;
    index_t         enc;
    logic           last;

    // Isolate the lowest set bit and encode it; a zero word encodes to 0.
    always_comb begin
        lowest = data_q & (~data_q + W'(1));
        enc    = '0;
        for (int i = 0; i < W; i++) begin
            if (lowest[i]) enc = index_t'(i);
        end
        last   = (data_q ^ lowest) == '0;
    end

    // Next-state and datapath update; defaults first so nothing holds implicitly.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.data_vld) begin
                    data_d  = bus.data_i;
                    count_d = '0;
                    state_d = (bus.data_i != '0) ? EMIT : FINISH;
                end
            end
            EMIT: begin
                if (bus.idx_rdy) begin
                    data_d  = data_q ^ lowest;
                    count_d = count_q + count_t'(1);
                    if (last) state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Outputs decode registered state only and are forced low while in reset.
    always_comb begin
        bus.ready    = rst_n && (state_q == IDLE);
        bus.idx_vld  = rst_n && (state_q == EMIT);
        bus.done_vld = rst_n && (state_q == FINISH);
        bus.idx_o    = rst_n ? enc : '0;
        bus.idx_last = rst_n && (state_q == EMIT) && last;
        bus.count_o  = rst_n ? count_q : '0;
    end

endmodule

// File: tb/tb_bit_index_emit.sv
// Directed and randomized checks of the set-bit index emitter (W = 8).

module tb_bit_index_emit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bit_index_emit_if bus ();

    bit_index_emit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]      word;
        logic [3:0]      n;
        logic [7:0][2:0] idx;   // element 0 is the first index expected
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (bus.ready !== 1'b1) check("ready_timeout", 32'(bus.ready), 1);
    endtask

    task automatic apply(input logic [7:0] w);
        wait_ready();
        bus.data_vld = 1'b1;
        bus.data_i   = w;
        tick();
        bus.data_vld = 1'b0;
    endtask

    // Accept a word with idx_rdy high and check the exact cycle-by-cycle stream.
    task automatic run_word(input logic [7:0] w, input logic [3:0] n, input logic [7:0][2:0] ix);
        bus.idx_rdy = 1'b1;
        apply(w);
        for (int j = 0; j < int'(n); j++) begin
            check("beat_vld",  32'(bus.idx_vld), 1);
            check("beat_idx",  32'(bus.idx_o), 32'(ix[j]));
            check("beat_last", 32'(bus.idx_last), (j == int'(n) - 1) ? 1 : 0);
            tick();
        end
        check("done_vld",  32'(bus.done_vld), 1);
        check("done_noidx", 32'(bus.idx_vld), 0);
        check("done_count", 32'(bus.count_o), 32'(n));
        tick();
        check("ready_after", 32'(bus.ready), 1);
        check("count_hold", 32'(bus.count_o), 32'(n));
    endtask

    initial begin
        vecs[0] = '{word: 8'hA5, n: 4'd4, idx: {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2, 3'd0}};
        vecs[1] = '{word: 8'h00, n: 4'd0, idx: '0};
        vecs[2] = '{word: 8'hFF, n: 4'd8, idx: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        vecs[3] = '{word: 8'h80, n: 4'd1, idx: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
        vecs[4] = '{word: 8'h6C, n: 4'd4, idx: {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd5, 3'd3, 3'd2}};
        vecs[5] = '{word: 8'h01, n: 4'd1, idx: '0};

        // Reset held with a live full word: everything forced low.
        bus.data_vld = 1'b1;
        bus.data_i   = 8'hFF;
        bus.idx_rdy  = 1'b0;
        rst_n        = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_ready", 32'(bus.ready), 0);
            check("rst_vld",   32'(bus.idx_vld), 0);
            check("rst_last",  32'(bus.idx_last), 0);
            check("rst_idx",   32'(bus.idx_o), 0);
            check("rst_done",  32'(bus.done_vld), 0);
            check("rst_count", 32'(bus.count_o), 0);
        end
        bus.data_vld = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("rel_ready", 32'(bus.ready), 1);

        // Table-driven words, including zero, full and MSB-only boundaries.
        for (int v = 0; v < 6; v++) run_word(vecs[v].word, vecs[v].n, vecs[v].idx);

        // Zero word: done exactly one cycle after accept.
        bus.idx_rdy = 1'b1;
        apply(8'h00);
        check("zero_novld", 32'(bus.idx_vld), 0);
        check("zero_done",  32'(bus.done_vld), 1);
        check("zero_count", 32'(bus.count_o), 0);
        tick();
        check("zero_ready", 32'(bus.ready), 1);

        // Backpressure on 8'h12 with idx_rdy = 0,0,1,0,1.
        bus.idx_rdy = 1'b0;
        apply(8'h12);
        check("bp_s0_idx",  32'(bus.idx_o), 1);
        check("bp_s0_last", 32'(bus.idx_last), 0);
        tick();
        check("bp_s1_vld",  32'(bus.idx_vld), 1);
        check("bp_s1_idx",  32'(bus.idx_o), 1);
        bus.idx_rdy = 1'b1;
        tick();
        check("bp_b1_idx",  32'(bus.idx_o), 4);
        check("bp_b1_last", 32'(bus.idx_last), 1);
        bus.idx_rdy = 1'b0;
        tick();
        check("bp_s2_idx",  32'(bus.idx_o), 4);
        check("bp_s2_last", 32'(bus.idx_last), 1);
        check("bp_s2_done", 32'(bus.done_vld), 0);
        bus.idx_rdy = 1'b1;
        tick();
        check("bp_done",    32'(bus.done_vld), 1);
        check("bp_count",   32'(bus.count_o), 2);
        tick();

        // Ignored input: 8'hFF offered throughout EMIT of 8'h03.
        bus.idx_rdy = 1'b1;
        apply(8'h03);
        bus.data_vld = 1'b1;
        bus.data_i   = 8'hFF;
        check("ign_b0", 32'(bus.idx_o), 0);
        tick();
        check("ign_b1",   32'(bus.idx_o), 1);
        check("ign_last", 32'(bus.idx_last), 1);
        tick();
        check("ign_done",  32'(bus.done_vld), 1);
        check("ign_count", 32'(bus.count_o), 2);
        tick();
        check("ign_ready", 32'(bus.ready), 1);
        tick();
        bus.data_vld = 1'b0;
        check("ign_ff_vld", 32'(bus.idx_vld), 1);
        check("ign_ff_idx", 32'(bus.idx_o), 0);
        for (int c = 0; c < 8; c++) tick();
        check("ign_ff_done",  32'(bus.done_vld), 1);
        check("ign_ff_count", 32'(bus.count_o), 8);
        tick();

        // Reset after two beats of 8'hF0 aborts the word without a done pulse.
        apply(8'hF0);
        check("mid_b0", 32'(bus.idx_o), 4);
        tick();
        check("mid_b1", 32'(bus.idx_o), 5);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(bus.idx_vld), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 32'(bus.ready), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_no_vld",  32'(bus.idx_vld), 0);
            check("mid_no_done", 32'(bus.done_vld), 0);
        end
        run_word(8'h01, 4'd1, '0);

        // Randomized back-to-back words with random downstream stalls.
        for (int w = 0; w < 1000; w++) begin
            logic [7:0] word;
            logic [7:0] rem;
            int         pc;
            int         cyc;
            bit         fin;
            word = (w % 17 == 0) ? 8'h00 : 8'($urandom);
            rem  = word;
            pc   = 0;
            for (int b = 0; b < 8; b++) pc += int'(word[b]);
            bus.idx_rdy = 1'($urandom);
            apply(word);
            fin = 1'b0;
            cyc = 0;
            while (!fin && cyc < 200) begin
                int exp_idx;
                exp_idx = 0;
                for (int b = 7; b >= 0; b--) if (rem[b]) exp_idx = b;
                check("rnd_excl", 32'(int'(bus.ready) + int'(bus.idx_vld) + int'(bus.done_vld)), 1);
                if (bus.idx_vld) begin
                    check("rnd_idx",  32'(bus.idx_o), 32'(exp_idx));
                    check("rnd_last", 32'(bus.idx_last), ((rem & ~(8'd1 << exp_idx)) == 8'h00) ? 1 : 0);
                    if (bus.idx_rdy) rem[exp_idx] = 1'b0;
                end else if (bus.done_vld) begin
                    check("rnd_count", 32'(bus.count_o), 32'(pc));
                    check("rnd_drain", 32'(rem), 0);
                    fin = 1'b1;
                end
                tick();
                bus.idx_rdy = 1'($urandom);
                cyc++;
            end
            if (!fin) check("rnd_timeout", 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
